// File: rtl/datapath_contador_duzias_pkg.sv
// Shared constants for the bottle/dozen counting datapath and its FSM.
// Digits are BCD, one nibble each.
package datapath_contador_duzias_pkg;
    localparam int MAX_GARRAFAS_DEF   = 12;
    localparam int MAX_DUZIAS_BCD_DEF = 99;
    localparam int BCD_W              = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/datapath_contador_duzias_digito.sv
// One BCD decade: counts 0..9 on en, carry is combinational.
// limpar clears synchronously and overrides en.
module contador_bcd_digito
    import datapath_contador_duzias_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             limpar,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    assign carry = en && (q == BCD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (limpar) begin
            q <= '0;
        end else if (en) begin
            q <= carry ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/datapath_contador_duzias.sv
// Bottle counter, BCD dozens total and lot-full flag, driven by
// rising edges of the dozen-counter FSM levels.
module datapath_contador_duzias
    import datapath_contador_duzias_pkg::*;
#(
    parameter int MAX_GARRAFAS   = MAX_GARRAFAS_DEF,
    parameter int MAX_DUZIAS_BCD = MAX_DUZIAS_BCD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cont1,
    input  logic             add_cont12,
    input  logic             limpar,
    output logic             cont12,
    output logic [3:0]       garrafas,
    output logic [BCD_W-1:0] duzias_uni,
    output logic [BCD_W-1:0] duzias_dez,
    output logic             duzia_ok,
    output logic             lote_cheio
);

    localparam logic [3:0] G_MAX = 4'(MAX_GARRAFAS);

    logic cont1_q;
    logic add_q;
    logic rise1;
    logic rise12;
    logic inc;
    logic en_uni;
    logic carry_uni;
    logic carry_dez;
    int   tot_now;
    int   tot_next;

    assign rise1  = cont1 && !cont1_q;
    assign rise12 = add_cont12 && !add_q;
    assign cont12 = (garrafas == G_MAX);

    assign inc    = rise12 && !lote_cheio && !limpar;
    // 99 is the BCD ceiling: freeze both digits there
    assign en_uni = inc &&
        !(duzias_uni == BCD_MAX && duzias_dez == BCD_MAX);

    always_comb begin
        tot_now  = 10 * int'(duzias_dez) + int'(duzias_uni);
        tot_next = en_uni ? tot_now + 1 : tot_now;
    end

    contador_bcd_digito u_uni (
        .clk    (clk),
        .reset  (reset),
        .limpar (limpar),
        .en     (en_uni),
        .q      (duzias_uni),
        .carry  (carry_uni)
    );

    contador_bcd_digito u_dez (
        .clk    (clk),
        .reset  (reset),
        .limpar (limpar),
        .en     (carry_uni),
        .q      (duzias_dez),
        .carry  (carry_dez)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont1_q    <= 1'b0;
            add_q      <= 1'b0;
            garrafas   <= '0;
            duzia_ok   <= 1'b0;
            lote_cheio <= 1'b0;
        end else begin
            cont1_q <= cont1;
            add_q   <= add_cont12;
            if (limpar) begin
                garrafas   <= '0;
                duzia_ok   <= 1'b0;
                lote_cheio <= 1'b0;
            end else if (rise12) begin
                // a coincident bottle edge is dropped
                garrafas <= '0;
                duzia_ok <= !lote_cheio;
                if (inc && tot_next == MAX_DUZIAS_BCD)
                    lote_cheio <= 1'b1;
            end else begin
                duzia_ok <= 1'b0;
                if (rise1 && garrafas != G_MAX)
                    garrafas <= garrafas + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_datapath_contador_duzias.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_datapath_contador_duzias;

    logic       clk = 1'b0;
    logic       reset;
    logic       cont1;
    logic       add_cont12;
    logic       limpar;
    logic       cont12;
    logic [3:0] garrafas;
    logic [3:0] duzias_uni;
    logic [3:0] duzias_dez;
    logic       duzia_ok;
    logic       lote_cheio;

    int tests  = 0;
    int failed = 0;

    // model state
    bit m_c1q, m_aq, m_ok, m_full;
    int m_g, m_tot;

    typedef struct {
        bit c1;
        bit a12;
        bit lp;
        int g;
        int uni;
        bit ok;
        bit c12;
    } vec_t;

    vec_t vt [10];

    datapath_contador_duzias dut (
        .clk        (clk),
        .reset      (reset),
        .cont1      (cont1),
        .add_cont12 (add_cont12),
        .limpar     (limpar),
        .cont12     (cont12),
        .garrafas   (garrafas),
        .duzias_uni (duzias_uni),
        .duzias_dez (duzias_dez),
        .duzia_ok   (duzia_ok),
        .lote_cheio (lote_cheio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_c1q  = 0;
        m_aq   = 0;
        m_ok   = 0;
        m_full = 0;
        m_g    = 0;
        m_tot  = 0;
    endtask

    task automatic model_edge();
        bit r1, r12;
        r1  = cont1 && !m_c1q;
        r12 = add_cont12 && !m_aq;
        if (limpar) begin
            m_g = 0; m_tot = 0; m_ok = 0; m_full = 0;
        end else if (r12) begin
            m_g = 0;
            if (!m_full) begin
                if (m_tot < 99) m_tot++;
                m_ok = 1;
                if (m_tot == 99) m_full = 1;
            end else begin
                m_ok = 0;
            end
        end else begin
            m_ok = 0;
            if (r1 && m_g < 12) m_g++;
        end
        m_c1q = cont1;
        m_aq  = add_cont12;
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".garrafas"}, 8'(garrafas), 8'(m_g));
        chk({nm, ".cont12"}, 8'(cont12), 8'(m_g == 12));
        chk({nm, ".uni"}, 8'(duzias_uni), 8'(m_tot % 10));
        chk({nm, ".dez"}, 8'(duzias_dez), 8'(m_tot / 10));
        chk({nm, ".ok"}, 8'(duzia_ok), 8'(m_ok));
        chk({nm, ".cheio"}, 8'(lote_cheio), 8'(m_full));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit c1, input bit a12, input bit lp);
        cont1      = c1;
        add_cont12 = a12;
        limpar     = lp;
        step();
    endtask

    task automatic bottle();
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
    endtask

    task automatic dozen();
        drive(0, 1, 0);
        drive(0, 0, 0);
    endtask

    task automatic clear();
        drive(0, 0, 1);
        drive(0, 0, 0);
    endtask

    int n_ok;

    initial begin
        vt[0] = '{1, 0, 0, 1, 0, 0, 0};
        vt[1] = '{1, 0, 0, 1, 0, 0, 0};
        vt[2] = '{0, 0, 0, 1, 0, 0, 0};
        vt[3] = '{1, 0, 0, 2, 0, 0, 0};
        vt[4] = '{1, 1, 0, 0, 1, 1, 0};
        vt[5] = '{0, 1, 0, 0, 1, 0, 0};
        vt[6] = '{1, 0, 0, 1, 1, 0, 0};
        vt[7] = '{0, 0, 1, 0, 0, 0, 0};
        vt[8] = '{0, 1, 0, 0, 1, 1, 0};
        vt[9] = '{0, 0, 0, 0, 1, 0, 0};

        reset = 1; cont1 = 0; add_cont12 = 0; limpar = 0;
        model_reset();
        #1;
        check_all("reset");
        #20;
        reset = 0;
        step();
        check_all("post_reset");

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].c1, vt[i].a12, vt[i].lp);
            chk($sformatf("vec%0d.g", i), 8'(garrafas), 8'(vt[i].g));
            chk($sformatf("vec%0d.uni", i), 8'(duzias_uni), 8'(vt[i].uni));
            chk($sformatf("vec%0d.ok", i), 8'(duzia_ok), 8'(vt[i].ok));
            chk($sformatf("vec%0d.c12", i), 8'(cont12), 8'(vt[i].c12));
        end

        // twelve bottles, cont12 and saturation
        clear();
        for (int i = 0; i < 11; i++) bottle();
        chk("b11.g", 8'(garrafas), 8'd11);
        chk("b11.c12", 8'(cont12), 8'd0);
        drive(1, 0, 0);
        chk("b12.g", 8'(garrafas), 8'd12);
        chk("b12.c12", 8'(cont12), 8'd1);
        drive(1, 0, 0);
        drive(0, 0, 0);
        bottle();
        chk("b13.g", 8'(garrafas), 8'd12);

        // held add_cont12 for three cycles
        drive(0, 1, 0);
        chk("add.g", 8'(garrafas), 8'd0);
        chk("add.uni", 8'(duzias_uni), 8'd1);
        chk("add.dez", 8'(duzias_dez), 8'd0);
        chk("add.ok1", 8'(duzia_ok), 8'd1);
        chk("add.c12", 8'(cont12), 8'd0);
        drive(0, 1, 0);
        chk("add.ok2", 8'(duzia_ok), 8'd0);
        drive(0, 1, 0);
        chk("add.ok3", 8'(duzia_ok), 8'd0);
        chk("add.uni3", 8'(duzias_uni), 8'd1);
        drive(0, 0, 0);

        // fill the lot to 99
        n_ok = 0;
        for (int i = 0; i < 97; i++) begin
            drive(0, 1, 0);
            n_ok += int'(duzia_ok);
            drive(0, 0, 0);
        end
        chk("lot98.ok_count", 8'(n_ok), 8'd97);
        chk("lot98.cheio", 8'(lote_cheio), 8'd0);
        dozen();
        chk("lot99.uni", 8'(duzias_uni), 8'd9);
        chk("lot99.dez", 8'(duzias_dez), 8'd9);
        chk("lot99.cheio", 8'(lote_cheio), 8'd1);
        for (int i = 0; i < 3; i++) bottle();
        drive(0, 1, 0);
        chk("lot100.ok", 8'(duzia_ok), 8'd0);
        chk("lot100.g", 8'(garrafas), 8'd0);
        chk("lot100.uni", 8'(duzias_uni), 8'd9);
        chk("lot100.dez", 8'(duzias_dez), 8'd9);
        chk("lot100.cheio", 8'(lote_cheio), 8'd1);
        drive(0, 0, 0);

        // units carry into tens
        clear();
        for (int i = 0; i < 9; i++) dozen();
        chk("carry.pre_uni", 8'(duzias_uni), 8'd9);
        chk("carry.pre_dez", 8'(duzias_dez), 8'd0);
        dozen();
        chk("carry.uni", 8'(duzias_uni), 8'd0);
        chk("carry.dez", 8'(duzias_dez), 8'd1);

        // coincident bottle and dozen edges
        clear();
        for (int i = 0; i < 5; i++) bottle();
        chk("coin.pre_g", 8'(garrafas), 8'd5);
        drive(1, 1, 0);
        chk("coin.g", 8'(garrafas), 8'd0);
        chk("coin.uni", 8'(duzias_uni), 8'd1);
        drive(0, 0, 0);

        // async reset mid-count, then limpar
        clear();
        for (int i = 0; i < 23; i++) dozen();
        for (int i = 0; i < 7; i++) bottle();
        chk("pre_rst.g", 8'(garrafas), 8'd7);
        chk("pre_rst.dez", 8'(duzias_dez), 8'd2);
        chk("pre_rst.uni", 8'(duzias_uni), 8'd3);
        cont1 = 1;
        #3;
        reset = 1;
        model_reset();
        #1;
        check_all("async_rst");
        #2;
        reset = 0;
        step();
        chk("rst_first_c1.g", 8'(garrafas), 8'd1);
        drive(0, 0, 0);
        dozen();
        dozen();
        bottle();
        drive(0, 0, 1);
        chk("limpar.g", 8'(garrafas), 8'd0);
        chk("limpar.uni", 8'(duzias_uni), 8'd0);
        chk("limpar.dez", 8'(duzias_dez), 8'd0);
        chk("limpar.ok", 8'(duzia_ok), 8'd0);
        chk("limpar.cheio", 8'(lote_cheio), 8'd0);
        drive(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cont1      = ($urandom_range(0, 99) < 45);
            add_cont12 = ($urandom_range(0, 99) < (i < 2000 ? 20 : 8));
            limpar     = ($urandom_range(0, 999) < 3);
            step();
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/datapath_contador_duzias.md
DATAPATH_CONTADOR_DUZIAS -- requirements
Module: datapath_contador_duzias

Interface
REQ-001 SHALL have parameter MAX_GARRAFAS, default 12, bottles per dozen (terminal count).
REQ-002 SHALL have parameter MAX_DUZIAS_BCD, default 99, lot limit in dozens, BCD range.
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cont1  input  1  level from dozen-counter FSM: one bottle counted.
REQ-006 SHALL have port add_cont12  input  1  level from dozen-counter FSM: one dozen complete.
REQ-007 SHALL have port limpar  input  1  synchronous clear of all counters and flags.
REQ-008 SHALL have port cont12  output  1  high while the bottle count equals MAX_GARRAFAS; fed back to the FSM.
REQ-009 SHALL have port garrafas  output  4  current bottle count, binary, 0..MAX_GARRAFAS.
REQ-010 SHALL have port duzias_uni  output  4  dozens total, BCD units digit.
REQ-011 SHALL have port duzias_dez  output  4  dozens total, BCD tens digit.
REQ-012 SHALL have port duzia_ok  output  1  one-cycle pulse per dozen accepted.
REQ-013 SHALL have port lote_cheio  output  1  sticky flag: dozens total reached MAX_DUZIAS_BCD.

Function
REQ-014 SHALL register cont1 and add_cont12 once each and act only on rising edges: input high now, registered copy low.
REQ-015 SHALL increment garrafas by 1 on the clock edge ending the cycle in which a cont1 rising edge is detected.
- A cont1 level held for N cycles SHALL count once.
REQ-016 SHALL drive cont12 combinationally from the garrafas register: cont12 = (garrafas == MAX_GARRAFAS).
- cont12 therefore rises exactly 1 cycle after the 12th cont1 rising edge.
REQ-017 SHALL saturate garrafas at MAX_GARRAFAS; a cont1 rising edge while garrafas == MAX_GARRAFAS SHALL be ignored.
REQ-018 On an add_cont12 rising edge, SHALL apply all of the following in the same clock edge:
- garrafas <= 0
- BCD dozens total += 1
- duzia_ok = 1 for exactly that one following cycle
REQ-019 SHALL increment the BCD total as follows:
- units 9 -> 0 with carry into tens
- tens 9 with units 9 -> no change
- no digit SHALL ever hold a value above 9
REQ-020 SHALL set lote_cheio on the edge where the total becomes MAX_DUZIAS_BCD; it SHALL remain set until reset or limpar.
REQ-021 While lote_cheio = 1, an add_cont12 rising edge SHALL:
- clear garrafas
- leave the total unchanged
- not pulse duzia_ok
REQ-022 If cont1 and add_cont12 rising edges coincide, add_cont12 SHALL win: garrafas <= 0, the bottle SHALL be dropped, and the dozen SHALL be counted.
REQ-023 limpar SHALL have priority over cont1 and add_cont12.
- Effect on the next edge: garrafas = 0, digits = 0, lote_cheio = 0, duzia_ok = 0.
- Edge-detect registers SHALL still sample their inputs.
REQ-024 A held add_cont12 level SHALL not re-trigger after garrafas clears; it re-arms only after the input returns low.

Reset
REQ-025 Asserting reset SHALL immediately force, without waiting for a clock edge:
- garrafas = 0, duzias_uni = 0, duzias_dez = 0
- duzia_ok = 0, lote_cheio = 0
- both edge-detect registers = 0
REQ-026 Reset asserted mid-count SHALL discard the partial dozen.
- The first cont1 high after release SHALL count as a rising edge.

Structure
REQ-027 MAX_GARRAFAS, MAX_DUZIAS_BCD and the 4-bit BCD digit width SHALL live in a shared include file used by this block and the dozen-counter FSM.
REQ-028 SHALL instantiate one sub-module, contador_bcd_digito, twice for the dozens digits.
- Ports: clk, reset, limpar, en, q[3:0], carry.
- carry is combinational: en && q == 9.
REQ-029 SHALL keep the edge detection, the bottle counter and the flag logic in the top module.

Verification
REQ-030 Bench SHALL drive 12 cont1 pulses of 2 cycles each (no add_cont12) -> garrafas = 12 and cont12 = 1 one cycle after the 12th edge; a 13th pulse leaves garrafas = 12.
REQ-031 Bench SHALL then assert add_cont12 for 3 cycles -> garrafas = 0, units = 1, tens = 0, duzia_ok high for exactly 1 cycle, cont12 = 0.
REQ-032 Bench SHALL run 99 dozen cycles -> tens = 9, units = 9, lote_cheio = 1; a 100th add_cont12 leaves the total at 99, no duzia_ok, garrafas = 0.
REQ-033 Bench SHALL preload units = 9 with tens = 0, then send one add_cont12 -> units = 0, tens = 1.
REQ-034 Bench SHALL raise cont1 and add_cont12 in the same cycle with garrafas = 5 -> garrafas = 0, total +1.
REQ-035 Bench SHALL assert reset asynchronously between clock edges with garrafas = 7 and total 23 -> all outputs 0 before the next posedge; a subsequent limpar with state nonzero -> all outputs 0 after 1 edge.
